// File: rtl/sipo_rx_pkg.sv
// Shared types and constants for the serial-in / parallel-out receiver.
// Holds the FSM state encoding, shift-register opcodes and the default word width.
package sipo_rx_pkg;

  localparam int SIPO_WIDTH_DEF = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SR_HOLD  = 2'd0,
    SR_LOAD  = 2'd1,
    SR_SHIFT = 2'd2,
    SR_CLEAR = 2'd3
  } sr_op_t;

  // Bit counter must hold values 0..WIDTH-1 with margin.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/sipo_shreg.sv
// Shift register and received-bit counter for sipo_rx.
// Bits enter at the MSB and move right, so the first bit of a word ends up in bit 0.
module sipo_shreg
  import sipo_rx_pkg::*;
#(
  parameter int WIDTH = SIPO_WIDTH_DEF,
  parameter int CW    = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  sr_op_t           op,
  input  logic             din,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] shift_word
);

  logic [WIDTH-1:0] shreg;
  logic             shreg_lsb_unused;

  // Value the register would take after shifting in din; on the final bit
  // this is the completed word, consumed directly by the output stage.
  assign shift_word       = {din, shreg[WIDTH-1:1]};
  assign shreg_lsb_unused = shreg[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
      count <= '0;
    end else begin
      unique case (op)
        SR_LOAD: begin
          shreg <= {din, {(WIDTH-1){1'b0}}};
          count <= CW'(1);
        end
        SR_SHIFT: begin
          shreg <= shift_word;
          count <= count + CW'(1);
        end
        SR_CLEAR: begin
          count <= '0;
        end
        default: begin
          shreg <= shreg;
          count <= count;
        end
      endcase
    end
  end

endmodule

// File: rtl/sipo_rx.sv
// Serial-to-parallel receiver: framing FSM plus a one-word output holding
// register with valid/ready handshake, overflow and framing-error pulses.
//
// state | meaning
// IDLE  | waiting for a qualified start-of-word bit
// SHIFT | word partially received, collecting bits 1..WIDTH-1
module sipo_rx
  import sipo_rx_pkg::*;
#(
  parameter int WIDTH = SIPO_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_vld,
  input  logic             sof,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  input  logic             dout_rdy,
  output logic             busy,
  output logic             ovf,
  output logic             frm_err
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  state_t           state_nxt;
  sr_op_t           sr_op;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] shift_word;
  logic             last_bit;
  logic             complete;
  logic             restart;

  sipo_shreg #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_shreg (
    .clk        (clk),
    .rst        (rst),
    .op         (sr_op),
    .din        (sin),
    .count      (count),
    .shift_word (shift_word)
  );

  assign last_bit = (count == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (sin_vld && sof) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (sin_vld && !sof && last_bit) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sr_op    = SR_HOLD;
    complete = 1'b0;
    restart  = 1'b0;
    busy     = (state == SHIFT);
    unique case (state)
      IDLE: begin
        if (sin_vld && sof) begin
          sr_op = SR_LOAD;
        end
      end
      SHIFT: begin
        if (sin_vld) begin
          if (sof) begin
            // A new start bit mid-word: drop the partial word and begin again.
            sr_op   = SR_LOAD;
            restart = 1'b1;
          end else if (last_bit) begin
            sr_op    = SR_CLEAR;
            complete = 1'b1;
          end else begin
            sr_op = SR_SHIFT;
          end
        end
      end
      default: sr_op = SR_HOLD;
    endcase
  end

  // Output holding register: a completed word is taken only if the slot is
  // empty or being emptied on the same edge; otherwise it is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout     <= '0;
      dout_vld <= 1'b0;
      ovf      <= 1'b0;
      frm_err  <= 1'b0;
    end else begin
      ovf     <= 1'b0;
      frm_err <= restart;
      if (complete) begin
        if (!dout_vld || dout_rdy) begin
          dout     <= shift_word;
          dout_vld <= 1'b1;
        end else begin
          ovf <= 1'b1;
        end
      end else if (dout_vld && dout_rdy) begin
        dout_vld <= 1'b0;
      end
    end
  end

endmodule

// File: doc/sipo_rx.md
SIPO_RX -- requirements
Module: sipo_rx

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 4, meaning the word length in bits (legal range 2..32).
REQ-002 Port clk SHALL be: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 Port rst SHALL be: input, 1 bit, reset; synchronous and active-high.
REQ-004 Port sin SHALL be: input, 1 bit, serial data, LSB of each word first.
REQ-005 Port sin_vld SHALL be: input, 1 bit, qualifies sin; sin is sampled only when sin_vld=1.
REQ-006 Port sof SHALL be: input, 1 bit, start-of-word; marks the current sin bit as bit 0; ignored when sin_vld=0.
REQ-007 Port dout SHALL be: output, WIDTH bits, the assembled parallel word.
REQ-008 Port dout_vld SHALL be: output, 1 bit, dout holds an unconsumed word.
REQ-009 Port dout_rdy SHALL be: input, 1 bit, the consumer accepts dout when dout_vld=1 and dout_rdy=1 at a rising edge.
REQ-010 Port busy SHALL be: output, 1 bit, high while a word is partially received.
REQ-011 Port ovf SHALL be: output, 1 bit, one-cycle pulse; a completed word was dropped.
REQ-012 Port frm_err SHALL be: output, 1 bit, one-cycle pulse; sof arrived mid-word.

Function
REQ-013 The FSM SHALL have two states, IDLE and SHIFT, with busy = (state==SHIFT).
REQ-014 In IDLE, sin_vld=1 with sof=1 SHALL load sin into the shift register, set the bit count to 1 and enter SHIFT; sin_vld=1 with sof=0 SHALL be ignored.
REQ-015 In SHIFT, sin_vld=1 with sof=0 SHALL shift right, inserting sin at the MSB ({sin, shreg[WIDTH-1:1]}), and increment the count; the first received bit SHALL therefore end in dout[0].
REQ-016 In SHIFT, sin_vld=0 SHALL hold the shift register, count and state unchanged; gaps of any length are legal.
REQ-017 On the edge that samples bit WIDTH-1, the FSM SHALL form the complete word, return to IDLE and clear the count; dout_vld SHALL be visible in the following cycle (latency: 1 clock after the last-bit edge).
REQ-018 In SHIFT, sin_vld=1 with sof=1 SHALL pulse frm_err for one cycle, discard the partial word, and restart with sin as bit 0 (count=1, remain in SHIFT).
REQ-019 When dout_vld=0, or dout_vld=1 with dout_rdy=1, a completed word SHALL be written to dout and dout_vld SHALL be 1.
REQ-020 When dout_vld=1 and dout_rdy=0 on the completing edge, the new word SHALL be dropped, dout SHALL keep the old word, and ovf SHALL pulse for one cycle.
REQ-021 An accept (dout_vld=1 and dout_rdy=1) with no simultaneous completion SHALL clear dout_vld; dout SHALL retain its last value.
REQ-022 dout SHALL change only on a completed word or on reset.

Reset
REQ-023 rst=1 at a rising edge SHALL force state=IDLE, count=0, shift register=0, dout=0, dout_vld=0, ovf=0 and frm_err=0, overriding all other inputs in that cycle.
REQ-024 A reset mid-word SHALL discard the partial word without asserting frm_err or ovf.

Structure
REQ-025 The state enum (IDLE, SHIFT) and the default WIDTH constant SHALL reside in the shared package sipo_rx_pkg.
REQ-026 The shift register and its bit counter SHALL be one sub-module, sipo_shreg (load, shift, hold, clear), instantiated once; the FSM and output handshake SHALL reside in sipo_rx.

Verification
REQ-027 The bench SHALL cover reset: hold rst=1 for 2 cycles with random inputs -> all outputs 0 and busy=0.
REQ-028 The bench SHALL cover a single word: WIDTH=4, dout_rdy=1, bits 1,1,1,0 on consecutive cycles with sof on the first -> dout=4'b0111 and dout_vld high for 1 cycle, one cycle after the 4th bit; busy high for 3 cycles.
REQ-029 The bench SHALL cover a gapped word: the same bits with 2 idle cycles (sin_vld=0) between each -> dout=4'b0111; no ovf and no frm_err.
REQ-030 The bench SHALL cover a framing error: sof, 2 bits, then sof with bits 0,1,0,1 -> frm_err pulses once, then dout=4'b1010.
REQ-031 The bench SHALL cover backpressure: dout_rdy=0 while words 4'b0011 and 4'b1100 are sent back-to-back -> dout=4'b0011 held, ovf pulses once; then dout_rdy=1 for one cycle -> dout_vld clears.
REQ-032 The bench SHALL cover reset mid-word: rst after 2 bits, then a full word 4'b1001 -> dout=4'b1001; frm_err and ovf stay 0 throughout.
